// File: rtl/fifo_pkg.sv
// Shared types and Gray-code helpers for the dual-clock FIFO.
// The converters live in a parameterised class so one definition serves every pointer width.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  virtual class gray_conv #(parameter int WIDTH = 5);

    static function logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] bin);
      return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it.
    static function logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] gray);
      logic [WIDTH-1:0] bin;
      bin = '0;
      for (int i = 0; i < WIDTH; i++) begin
        bin[i] = ^(gray >> i);
      end
      return bin;
    endfunction

  endclass

endpackage

// File: rtl/gray_ptr_sync.sv
// Two-flop synchronizer carrying a Gray-coded pointer into the destination clock domain.
module gray_ptr_sync #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] gray_sync
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= gray_in;
      sync_reg <= meta_reg;
    end
  end

  assign gray_sync = sync_reg;

endmodule

// File: rtl/async_fifo_lvl.sv
// Dual-clock FIFO with registered full/empty, per-domain fill levels, almost thresholds,
// sticky overflow/underflow flags and a choice of FWFT or registered-read output.
module async_fifo_lvl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 2,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 1
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  woverflow,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  rempty,
  output logic                  ralmost_empty,
  output logic [ADDR_WIDTH:0]   rlevel,
  output logic                  runderflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ---------------- write domain ----------------
  logic [PTR_W-1:0] wbin_reg, wgray_reg, wlevel_reg;
  logic [PTR_W-1:0] wbin_next, wgray_next, wlevel_next;
  logic [PTR_W-1:0] rgray_wsync, rbin_wsync;
  logic             wfull_reg, walmost_full_reg, woverflow_reg;
  logic             wfull_next, walmost_full_next;
  logic             winc;

  assign winc       = wen && !wfull_reg;
  assign wbin_next  = wbin_reg + PTR_W'(winc);
  assign wgray_next = gray_conv#(PTR_W)::bin2gray(wbin_next);
  assign rbin_wsync = gray_conv#(PTR_W)::gray2bin(rgray_wsync);

  // Full when the write pointer has lapped the read pointer by exactly one DEPTH.
  assign wfull_next = (wgray_next == {~rgray_wsync[PTR_W-1 -: 2], rgray_wsync[PTR_W-3:0]});
  assign wlevel_next       = wbin_next - rbin_wsync;
  assign walmost_full_next = (DEPTH - int'(wlevel_next)) <= AF_THRESH;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_reg         <= '0;
      wgray_reg        <= '0;
      wlevel_reg       <= '0;
      wfull_reg        <= 1'b0;
      walmost_full_reg <= 1'b0;
      woverflow_reg    <= 1'b0;
    end else begin
      wbin_reg         <= wbin_next;
      wgray_reg        <= wgray_next;
      wlevel_reg       <= wlevel_next;
      wfull_reg        <= wfull_next;
      walmost_full_reg <= walmost_full_next;
      woverflow_reg    <= woverflow_reg || (wen && wfull_reg);
    end
  end

  always_ff @(posedge wclk) begin
    if (winc) begin
      mem[wbin_reg[ADDR_WIDTH-1:0]] <= wdata;
    end
  end

  assign wfull        = wfull_reg;
  assign walmost_full = walmost_full_reg;
  assign wlevel       = wlevel_reg;
  assign woverflow    = woverflow_reg;

  // ---------------- pointer crossings ----------------
  logic [PTR_W-1:0] rgray_reg;
  logic [PTR_W-1:0] wgray_rsync;

  gray_ptr_sync #(.WIDTH(PTR_W)) u_rptr_to_wclk (
    .clk       (wclk),
    .rst_n     (wrst_n),
    .gray_in   (rgray_reg),
    .gray_sync (rgray_wsync)
  );

  gray_ptr_sync #(.WIDTH(PTR_W)) u_wptr_to_rclk (
    .clk       (rclk),
    .rst_n     (rrst_n),
    .gray_in   (wgray_reg),
    .gray_sync (wgray_rsync)
  );

  // ---------------- read domain ----------------
  logic [PTR_W-1:0] rbin_reg, rlevel_reg;
  logic [PTR_W-1:0] rbin_next, rgray_next, rlevel_next;
  logic [PTR_W-1:0] wbin_rsync;
  logic             rempty_reg, ralmost_empty_reg, runderflow_reg;
  logic             rempty_next, ralmost_empty_next;
  logic             rinc;

  assign rinc       = ren && !rempty_reg;
  assign rbin_next  = rbin_reg + PTR_W'(rinc);
  assign rgray_next = gray_conv#(PTR_W)::bin2gray(rbin_next);
  assign wbin_rsync = gray_conv#(PTR_W)::gray2bin(wgray_rsync);

  assign rempty_next        = (rgray_next == wgray_rsync);
  assign rlevel_next        = wbin_rsync - rbin_next;
  assign ralmost_empty_next = int'(rlevel_next) <= AE_THRESH;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_reg          <= '0;
      rgray_reg         <= '0;
      rlevel_reg        <= '0;
      rempty_reg        <= 1'b1;
      ralmost_empty_reg <= 1'b1;
      runderflow_reg    <= 1'b0;
    end else begin
      rbin_reg          <= rbin_next;
      rgray_reg         <= rgray_next;
      rlevel_reg        <= rlevel_next;
      rempty_reg        <= rempty_next;
      ralmost_empty_reg <= ralmost_empty_next;
      runderflow_reg    <= runderflow_reg || (ren && rempty_reg);
    end
  end

  assign rempty        = rempty_reg;
  assign ralmost_empty = ralmost_empty_reg;
  assign rlevel        = rlevel_reg;
  assign runderflow    = runderflow_reg;

  generate
    if (MODE == FIFO_FWFT) begin : g_fwft
      // Head word is shown directly; forced to zero while empty so reset reads as zero.
      assign rdata  = rempty_reg ? '0 : mem[rbin_reg[ADDR_WIDTH-1:0]];
      assign rvalid = !rempty_reg;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rdata_reg;
      logic                  rvalid_reg;

      always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
          rdata_reg  <= '0;
          rvalid_reg <= 1'b0;
        end else begin
          rvalid_reg <= rinc;
          if (rinc) begin
            rdata_reg <= mem[rbin_reg[ADDR_WIDTH-1:0]];
          end
        end
      end

      assign rdata  = rdata_reg;
      assign rvalid = rvalid_reg;
    end
  endgenerate

endmodule
